// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND
  } arb_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  function automatic int unsigned onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or after rr_ptr.
module rr_picker #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    owner = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        owner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared uart_tx with frame lock, burst cap and idle timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ-1:0]            start_in,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                        tx_active,
  input  logic                        tx_done,
  output logic [N_REQ-1:0]            grant,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        busy,
  output logic                        timeout_evt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned IW    = $clog2(TIMEOUT);
  localparam int unsigned BW    = $clog2(MAX_BURST + 1);

  arb_state_t              state_q, state_n;
  logic [IDX_W-1:0]        owner_q, owner_n;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_n;
  logic [IW-1:0]           idle_cnt_q, idle_cnt_n;
  logic [BW-1:0]           burst_cnt_q, burst_cnt_n;
  logic [N_REQ-1:0]        grant_n;
  logic                    tx_start_n;
  logic [DATA_WIDTH-1:0]   tx_data_n;
  logic                    timeout_n;
  logic                    rel;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_owner;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .owner  (pick_owner)
  );

  always_comb begin
    state_n     = state_q;
    owner_n     = owner_q;
    rr_ptr_n    = rr_ptr_q;
    idle_cnt_n  = idle_cnt_q;
    burst_cnt_n = burst_cnt_q;
    grant_n     = grant;
    tx_start_n  = 1'b0;
    tx_data_n   = tx_data;
    timeout_n   = 1'b0;
    rel         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // tx_active guards against a byte still in flight from before a reset
        if (!tx_active && pick_valid) begin
          owner_n     = pick_owner;
          grant_n     = N_REQ'(onehot(32'(pick_owner)));
          idle_cnt_n  = '0;
          burst_cnt_n = '0;
          state_n     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (idle_cnt_q != IW'(TIMEOUT - 1))
          idle_cnt_n = idle_cnt_q + IW'(1);
        // start has priority over both req falling and timeout
        if (start_in[owner_q]) begin
          tx_data_n   = data_in[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
          tx_start_n  = 1'b1;
          burst_cnt_n = burst_cnt_q + BW'(1);
          state_n     = ST_SEND;
        end else if (!req[owner_q]) begin
          rel = 1'b1;
        end else if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          rel       = 1'b1;
          timeout_n = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          if (lock[owner_q] && req[owner_q] && (burst_cnt_q < BW'(MAX_BURST))) begin
            idle_cnt_n = '0;
            state_n    = ST_GRANT;
          end else begin
            rel = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (rel) begin
      grant_n  = '0;
      rr_ptr_n = IDX_W'(wrap_inc(32'(owner_q), N_REQ));
      state_n  = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      burst_cnt_q <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state_q     <= state_n;
      owner_q     <= owner_n;
      rr_ptr_q    <= rr_ptr_n;
      idle_cnt_q  <= idle_cnt_n;
      burst_cnt_q <= burst_cnt_n;
      grant       <= grant_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      busy        <= (state_n != ST_IDLE);
      timeout_evt <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, lock, start_in;
  logic [31:0] data_in;
  logic        tx_active, tx_done;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, timeout_evt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .TIMEOUT(16), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .start_in(start_in),
    .data_in(data_in), .tx_active(tx_active), .tx_done(tx_done),
    .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .timeout_evt(timeout_evt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req, lock, start;
    logic [31:0] data;
    logic        act, done;
    logic [3:0]  g;
    logic        ts;
    logic [7:0]  td;
    logic        b, to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] rq, logic [3:0] lk, logic [3:0] st,
                              logic [31:0] d, logic act, logic done, logic [3:0] g,
                              logic ts, logic [7:0] td, logic b, logic to);
    vec_t v;
    v.rst = rst; v.req = rq; v.lock = lk; v.start = st; v.data = d; v.act = act;
    v.done = done; v.g = g; v.ts = ts; v.td = td; v.b = b; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; start_in = '0; data_in = '0; tx_active = 1'b0; tx_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // owner k sends byte d; exp_g is the grant required after tx_done
  task automatic send_byte(input string name, input int k, input logic [7:0] d,
                           input logic [3:0] exp_g);
    start_in = 4'(1 << k);
    data_in[k*8 +: 8] = d;
    tick();
    check({name, ".tx_start"}, 32'(tx_start), 32'd1);
    check({name, ".tx_data"}, 32'(tx_data), 32'(d));
    start_in = '0;
    tx_active = 1'b1;
    tick();
    check({name, ".single_pulse"}, 32'(tx_start), 32'd0);
    tick();
    tx_active = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check({name, ".grant_after_done"}, 32'(grant), 32'(exp_g));
  endtask

  initial begin
    int order[5];
    int cnt;
    int early_to;
    logic [7:0] prev_td;

    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    idle_inputs();

    // single requester
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 32'h0,  0, 0, 4'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 4'h0, 32'h0,  0, 0, 4'h1, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 4'h1, 32'h41, 0, 0, 4'h1, 1, 8'h41, 1, 0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 4'h1, 32'h99, 1, 0, 4'h1, 0, 8'h41, 1, 0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 4'h0, 32'h0,  1, 0, 4'h1, 0, 8'h41, 1, 0));
    vecs.push_back(mk(0, 4'h1, 4'h0, 4'h0, 32'h0,  0, 1, 4'h0, 0, 8'h41, 0, 0));
    vecs.push_back(mk(0, 4'h0, 4'h0, 4'h0, 32'h0,  0, 0, 4'h0, 0, 8'h41, 0, 0));
    // round-robin with all requesting; non-owner strobes must be ignored
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 32'h0,  0, 0, 4'h0, 0, 8'h00, 0, 0));
    prev_td = 8'h00;
    foreach (order[i]) begin
      vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 32'hD3D2D1D0, 0, 0,
                        4'(1 << order[i]), 0, prev_td, 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, 4'hF, 32'hD3D2D1D0, 0, 0,
                        4'(1 << order[i]), 1, 8'(8'hD0 + order[i]), 1, 0));
      vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 32'hD3D2D1D0, 0, 1,
                        4'h0, 0, 8'(8'hD0 + order[i]), 0, 0));
      prev_td = 8'(8'hD0 + order[i]);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; req = vecs[i].req; lock = vecs[i].lock;
      start_in = vecs[i].start; data_in = vecs[i].data;
      tx_active = vecs[i].act; tx_done = vecs[i].done;
      tick();
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(vecs[i].ts));
      check($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(vecs[i].td));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].b));
      check($sformatf("vec%0d.timeout_evt", i), 32'(timeout_evt), 32'(vecs[i].to));
    end
    reset = 1'b0;

    // locked frame from owner 2 while owner 0 waits
    do_reset();
    req = 4'b0100; lock = 4'b0100;
    tick();
    check("lock.grant", 32'(grant), 32'h4);
    req = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      lock = (b == 2) ? 4'b0000 : 4'b0100;
      send_byte($sformatf("lock.b%0d", b), 2, 8'(8'h10 + b), (b == 2) ? 4'h0 : 4'h4);
    end
    tick();
    check("lock.next_owner", 32'(grant), 32'h1);

    // burst cap of 4 for a locked owner that keeps strobing
    do_reset();
    req = 4'b0010; lock = 4'b0010;
    tick();
    check("burst.grant", 32'(grant), 32'h2);
    req = 4'b1010;
    for (int b = 0; b < 4; b++)
      send_byte($sformatf("burst.b%0d", b), 1, 8'(8'h20 + b), (b == 3) ? 4'h0 : 4'h2);
    start_in = 4'b0010;
    tick();
    check("burst.next_owner", 32'(grant), 32'h8);
    check("burst.no_extra_start", 32'(tx_start), 32'd0);
    start_in = '0;

    // idle timeout: 16 GRANT cycles, then revoke
    do_reset();
    req = 4'b0011;
    tick();
    cnt = 0;
    early_to = 0;
    for (int c = 0; c < 40; c++) begin
      if (grant != 4'b0001) break;
      cnt++;
      if (timeout_evt) early_to++;
      tick();
    end
    check("timeout.grant_cycles", 32'(cnt), 32'd16);
    check("timeout.early_evt", 32'(early_to), 32'd0);
    check("timeout.evt", 32'(timeout_evt), 32'd1);
    check("timeout.grant_cleared", 32'(grant), 32'h0);
    tick();
    check("timeout.evt_one_cycle", 32'(timeout_evt), 32'd0);
    check("timeout.next_owner", 32'(grant), 32'h2);

    // start on the timeout cycle wins
    do_reset();
    req = 4'b0001;
    tick();
    repeat (15) tick();
    check("to_start.still_granted", 32'(grant), 32'h1);
    start_in = 4'b0001; data_in = 32'h5A;
    tick();
    start_in = '0;
    check("to_start.tx_start", 32'(tx_start), 32'd1);
    check("to_start.tx_data", 32'(tx_data), 32'h5A);
    check("to_start.no_evt", 32'(timeout_evt), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("to_start.release", 32'(grant), 32'h0);

    // start in the same cycle req falls
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000; start_in = 4'b0001; data_in = 32'h77;
    tick();
    start_in = '0;
    check("reqfall.tx_start", 32'(tx_start), 32'd1);
    check("reqfall.tx_data", 32'(tx_data), 32'h77);
    check("reqfall.grant", 32'(grant), 32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("reqfall.release", 32'(grant), 32'h0);

    // reset during SEND with uart_tx still busy
    do_reset();
    req = 4'b0001;
    tick();
    start_in = 4'b0001; data_in = 32'h33;
    tick();
    start_in = '0;
    tx_active = 1'b1;
    reset = 1'b1;
    tick();
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.tx_start", 32'(tx_start), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'h0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.timeout_evt", 32'(timeout_evt), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst.blocked%0d", c), 32'(grant), 32'h0);
    end
    tx_active = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("rst.regrant", 32'(grant), 32'h1);
    check("rst.busy_after", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
